// File: rtl/tri_bus_arbiter.sv
// Purpose: round-robin owner selection for one shared tri-state net, with a turnaround gap and hold-limit preemption.
// Latency: oe rises on the edge after req is seen in IDLE or on the last gap cycle; it drops on the edge after release or expiry.
// Backpressure: none; req is a level that the requester holds until it is done, and oe is the only grant.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset; clears oe immediately
//   req      per-requester level request
//   oe       one-hot-or-zero driver enable, registered
//   owner    index of current owner, valid while bus_busy=1
//   bus_busy 1 while any oe bit is set
//   preempt  one-cycle pulse when the owner is removed by hold-limit expiry
module tri_bus_arbiter #(
    parameter int N_REQ      = 4,
    parameter int TURNAROUND = 1,
    parameter int MAX_HOLD   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         oe,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     bus_busy,
    output logic                     preempt
);

    localparam int OW = $clog2(N_REQ);
    // MAX_HOLD=0 means unlimited; the counter still needs one bit.
    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic [HW-1:0] HOLD_SAT  = {HW{1'b1}};
    localparam logic [3:0]    GAP_INIT  = 4'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);
    localparam logic [OW-1:0] RR_INIT   = OW'(N_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OWN  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [3:0]      gap_cnt_q, gap_cnt_d;
    logic [OW-1:0]   rr_last_q, rr_last_d;
    logic [N_REQ-1:0] oe_d;
    logic [OW-1:0]   owner_d;
    logic            bus_busy_d;
    logic            preempt_d;

    // Round-robin pick: the lowest requester above rr_last wins; if none,
    // wrap to the lowest requester overall. Descending scan leaves the
    // lowest matching index in each candidate.
    logic            hi_found;
    logic [OW-1:0]   hi_idx;
    logic [OW-1:0]   lo_idx;
    logic            arb_found;
    logic [OW-1:0]   arb_idx;

    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_idx = OW'(i);
                if (i > int'(rr_last_q)) begin
                    hi_found = 1'b1;
                    hi_idx   = OW'(i);
                end
            end
        end
        arb_found = |req;
        arb_idx   = hi_found ? hi_idx : lo_idx;
    end

    logic grant;
    logic leave;

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        rr_last_d  = rr_last_q;
        oe_d       = oe;
        owner_d    = owner;
        bus_busy_d = bus_busy;
        preempt_d  = 1'b0;
        grant      = 1'b0;
        leave      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    grant = 1'b1;
                end
            end

            S_OWN: begin
                if (hold_cnt_q != HOLD_SAT) begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
                // A release in the expiry cycle wins, so preempt stays low.
                if (!req[owner]) begin
                    leave = 1'b1;
                end else if ((MAX_HOLD > 0) && (hold_cnt_q == HOLD_LAST)) begin
                    leave     = 1'b1;
                    preempt_d = 1'b1;
                end
                if (leave) begin
                    if (TURNAROUND > 0) begin
                        state_d    = S_GAP;
                        gap_cnt_d  = GAP_INIT;
                        oe_d       = '0;
                        bus_busy_d = 1'b0;
                    end else if (arb_found) begin
                        // Zero turnaround: hand over on the same edge.
                        // rr_last equals the outgoing owner here, so a
                        // preempted owner still requesting is lowest priority.
                        grant = 1'b1;
                    end else begin
                        state_d    = S_IDLE;
                        oe_d       = '0;
                        bus_busy_d = 1'b0;
                    end
                end
            end

            S_GAP: begin
                if (gap_cnt_q == 4'd0) begin
                    if (arb_found) begin
                        grant = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end

            default: begin
                state_d    = S_IDLE;
                oe_d       = '0;
                bus_busy_d = 1'b0;
            end
        endcase

        if (grant) begin
            state_d       = S_OWN;
            oe_d          = '0;
            oe_d[arb_idx] = 1'b1;
            owner_d       = arb_idx;
            bus_busy_d    = 1'b1;
            hold_cnt_d    = '0;
            rr_last_d     = arb_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            hold_cnt_q <= '0;
            gap_cnt_q  <= '0;
            rr_last_q  <= RR_INIT;
            oe         <= '0;
            owner      <= '0;
            bus_busy   <= 1'b0;
            preempt    <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            rr_last_q  <= rr_last_d;
            oe         <= oe_d;
            owner      <= owner_d;
            bus_busy   <= bus_busy_d;
            preempt    <= preempt_d;
        end
    end

endmodule

// File: tb/tb_tri_bus_arbiter.sv
module tb_tri_bus_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req_a, req_b, req_c;
    logic [3:0] oe_a, oe_b, oe_c;
    logic [1:0] owner_a, owner_b, owner_c;
    logic       busy_a, busy_b, busy_c;
    logic       pre_a, pre_b, pre_c;

    int n_cmp;
    int n_fail;

    // Value each requester puts on the shared net while enabled.
    wire [3:0] drv_val = 4'b1100;

    tri0 net_a0;
    tri1 net_a1;
    tri0 net_c0;
    tri1 net_c1;

    for (genvar g = 0; g < 4; g++) begin : g_drv
        assign net_a0 = oe_a[g] ? drv_val[g] : 1'bz;
        assign net_a1 = oe_a[g] ? drv_val[g] : 1'bz;
        assign net_c0 = oe_c[g] ? drv_val[g] : 1'bz;
        assign net_c1 = oe_c[g] ? drv_val[g] : 1'bz;
    end

    tri_bus_arbiter #(.N_REQ(4), .TURNAROUND(1), .MAX_HOLD(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req_a), .oe(oe_a),
        .owner(owner_a), .bus_busy(busy_a), .preempt(pre_a)
    );

    tri_bus_arbiter #(.N_REQ(4), .TURNAROUND(1), .MAX_HOLD(4)) u_dut_mh (
        .clk(clk), .rst_n(rst_n), .req(req_b), .oe(oe_b),
        .owner(owner_b), .bus_busy(busy_b), .preempt(pre_b)
    );

    tri_bus_arbiter #(.N_REQ(4), .TURNAROUND(0), .MAX_HOLD(16)) u_dut_t0 (
        .clk(clk), .rst_n(rst_n), .req(req_c), .oe(oe_c),
        .owner(owner_c), .bus_busy(busy_c), .preempt(pre_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and sample just after the edge; one-hot-or-zero
    // is checked on every instance every cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        chk("onehot_a", 16'($countones(oe_a) <= 1), 16'd1);
        chk("onehot_b", 16'($countones(oe_b) <= 1), 16'd1);
        chk("onehot_c", 16'($countones(oe_c) <= 1), 16'd1);
    endtask

    initial begin
        logic [1:0] order [4];
        n_cmp  = 0;
        n_fail = 0;
        req_a  = 4'b0000;
        req_b  = 4'b0000;
        req_c  = 4'b0000;
        rst_n  = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        // Reset state, taken before any clock edge.
        chk("rst_oe",      16'(oe_a),    16'h0);
        chk("rst_owner",   16'(owner_a), 16'h0);
        chk("rst_busy",    16'(busy_a),  16'h0);
        chk("rst_preempt", 16'(pre_a),   16'h0);
        chk("rst_net1",    16'(net_a1),  16'h1);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: single requester, one-cycle grant latency, release.
        req_a = 4'b0001;
        tick();
        chk("t1_oe",    16'(oe_a),    16'h1);
        chk("t1_owner", 16'(owner_a), 16'h0);
        chk("t1_busy",  16'(busy_a),  16'h1);
        chk("t1_net1",  16'(net_a1),  16'h0);
        tick(); tick(); tick();
        chk("t1_hold", 16'(oe_a), 16'h1);
        req_a = 4'b0000;
        tick();
        chk("t1_rel_oe",   16'(oe_a),   16'h0);
        chk("t1_rel_busy", 16'(busy_a), 16'h0);
        chk("t1_gap_net1", 16'(net_a1), 16'h1);
        chk("t1_gap_net0", 16'(net_a0), 16'h0);
        tick();

        // 2: all requesting; rr_last is 0 after test 1, so order is 1,2,3,0.
        order[0] = 2'd1; order[1] = 2'd2; order[2] = 2'd3; order[3] = 2'd0;
        req_a = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t2_oe",    16'(oe_a),    16'(4'b0001 << order[k]));
            chk("t2_owner", 16'(owner_a), 16'(order[k]));
            chk("t2_net1",  16'(net_a1),  16'(drv_val[order[k]]));
            tick();
            chk("t2_oe2", 16'(oe_a), 16'(4'b0001 << order[k]));
            req_a[order[k]] = 1'b0;
            tick();
            chk("t2_gap_oe",   16'(oe_a),   16'h0);
            chk("t2_gap_net0", 16'(net_a0), 16'h0);
            if (k < 3) req_a[order[k]] = 1'b1;
            else       req_a = 4'b0000;
        end
        tick();
        chk("t2_idle", 16'(oe_a), 16'h0);

        // 3: MAX_HOLD=4 with two requesters holding.
        req_b = 4'b0011;
        tick();
        chk("t3_own0", 16'(oe_b), 16'h1);
        tick(); tick(); tick();
        chk("t3_own0_last", 16'(oe_b), 16'h1);
        chk("t3_no_pre",    16'(pre_b), 16'h0);
        tick();
        chk("t3_pre0",    16'(pre_b), 16'h1);
        chk("t3_gap0_oe", 16'(oe_b),  16'h0);
        tick();
        chk("t3_own1",      16'(oe_b),    16'h2);
        chk("t3_own1_idx",  16'(owner_b), 16'h1);
        chk("t3_pre_pulse", 16'(pre_b),   16'h0);
        tick(); tick(); tick();
        chk("t3_own1_last", 16'(oe_b), 16'h2);
        tick();
        chk("t3_pre1",    16'(pre_b), 16'h1);
        chk("t3_gap1_oe", 16'(oe_b),  16'h0);
        tick();
        chk("t3_own0_again", 16'(oe_b), 16'h1);

        // 5: release coincides with expiry; late request during the gap.
        tick(); tick(); tick();
        chk("t5_hold3", 16'(oe_b), 16'h1);
        req_b = 4'b0000;
        tick();
        chk("t5_rel_oe",  16'(oe_b),  16'h0);
        chk("t5_rel_pre", 16'(pre_b), 16'h0);
        req_b = 4'b0100;
        tick();
        chk("t5_gap_grant", 16'(oe_b),    16'h4);
        chk("t5_gap_owner", 16'(owner_b), 16'h2);
        req_b = 4'b0000;
        tick();
        chk("t5_end", 16'(oe_b), 16'h0);

        // 4: zero turnaround, one-hot to one-hot handover.
        req_c = 4'b0110;
        tick();
        chk("t4_own1",  16'(oe_c),   16'h2);
        chk("t4_net0a", 16'(net_c0), 16'h0);
        req_c = 4'b0100;
        tick();
        chk("t4_b2b",   16'(oe_c),   16'h4);
        chk("t4_busy",  16'(busy_c), 16'h1);
        chk("t4_net0b", 16'(net_c0), 16'h1);
        chk("t4_net1b", 16'(net_c1), 16'h1);
        req_c = 4'b0000;
        tick();
        chk("t4_idle",  16'(oe_c),   16'h0);
        chk("t4_net0c", 16'(net_c0), 16'h0);

        // 6: asynchronous reset in the middle of an ownership.
        req_a = 4'b0100;
        tick();
        chk("t6_own2", 16'(oe_a), 16'h4);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_async_oe",   16'(oe_a),   16'h0);
        chk("t6_async_busy", 16'(busy_a), 16'h0);
        req_a = 4'b1000;
        #1 rst_n = 1'b1;
        tick();
        chk("t6_oe3",    16'(oe_a),    16'h8);
        chk("t6_owner3", 16'(owner_a), 16'h3);
        req_a = 4'b0000;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/tri_bus_arbiter.md
Name: tri_bus_arbiter

Overview:
- Round-robin arbiter that shares one multi-driver tri-state net among N_REQ requesters.
- Issues one-hot driver enables so at most one continuous-assign driver is non-z at any time.
- Inserts a programmable turnaround gap between successive owners.
- Preempts an owner that holds the bus past a limit. Sits in front of a resolved net (tri/tri0/tri1) whose undriven value the bench can observe.

Parameters:
N_REQ, 4, number of requesters (2..16)
TURNAROUND, 1, all-z cycles forced between two consecutive owners (0..15)
MAX_HOLD, 16, maximum consecutive owned cycles before preemption; 0 = unlimited

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req  input  N_REQ  request per requester, level, held until done
oe  output  N_REQ  one-hot-or-zero driver enable; requester i drives the net only while oe[i]=1
owner  output  clog2(N_REQ)  index of current owner; valid only while bus_busy=1
bus_busy  output  1  1 when any oe bit is set
preempt  output  1  one-cycle pulse when the owner is removed by MAX_HOLD expiry

Behaviour:
- Reset: async on rst_n=0. oe=0, owner=0, bus_busy=0, preempt=0, state=IDLE, hold_cnt=0, gap_cnt=0, rr_last=N_REQ-1, so req[0] has highest priority after reset. All outputs are registered.
- States: IDLE, OWN, GAP.
- Arbitration (combinational, used in IDLE and on the last GAP cycle):
  - Search req starting at index (rr_last+1) mod N_REQ, ascending with wrap.
  - The first set bit wins.
  - rr_last updates to the winner when OWN is entered.
- IDLE:
  - If any req is set, the next edge enters OWN: oe[winner]=1, owner=winner, hold_cnt=0. Latency from req rising to oe is 1 cycle.
  - Otherwise stay in IDLE.
- OWN:
  - hold_cnt increments each cycle, saturating.
  - Release: req[owner]=0 sampled. Next edge clears oe.
  - Preemption: MAX_HOLD>0 and hold_cnt==MAX_HOLD-1 and req[owner] still 1. Next edge clears oe and pulses preempt for exactly 1 cycle. The owner therefore drives exactly MAX_HOLD cycles.
  - If release and expiry coincide, it is treated as a release; preempt stays 0.
  - On leaving OWN:
    - TURNAROUND>0: go to GAP with gap_cnt=TURNAROUND-1.
    - TURNAROUND=0: arbitrate in the same cycle. A winner enters OWN directly, giving back-to-back ownership with oe changing one-hot to one-hot and no all-zero cycle. No winner goes to IDLE.
- GAP:
  - oe=0 throughout; gap_cnt decrements.
  - When gap_cnt==0, arbitrate: a winner enters OWN, otherwise go to IDLE.
  - Exactly TURNAROUND cycles have oe=0 between two owners.
- A preempted requester still holding req is lowest priority, because rr_last equals its index. It regains the bus after the gap only if it is the sole requester.
- req bits of non-owners may toggle freely; only the value at the arbitration edge matters.
- Invariant: popcount(oe)<=1 in every cycle, including reset assertion/deassertion.
- Reset mid-ownership: oe drops to 0 asynchronously without waiting for a clock.
- Widths:
  - hold_cnt is clog2(MAX_HOLD+1) bits.
  - gap_cnt is 4 bits.
  - owner is clog2(N_REQ), minimum 1 bit.

Test Plan:
1. Reset, then req=4'b0001 at cycle 0 -> oe=0001 and owner=0 at cycle 1. req=0 at cycle 5 -> oe=0 at cycle 6; net reads z (tri) / 0 (tri0) / 1 (tri1) during the gap.
2. Round robin, req=4'b1111 held with each owner dropping req after 2 cycles, TURNAROUND=1 -> grant order 0,1,2,3,0. Exactly one all-z cycle between owners; popcount(oe)<=1 every cycle.
3. MAX_HOLD=4, req=4'b0011 held high -> owner 0 drives 4 cycles, preempt pulses 1 cycle, 1 gap cycle, owner 1 gets the bus, then owner 0 after owner 1's 4 cycles.
4. TURNAROUND=0, req=4'b0110 with owner 1 releasing -> oe goes 0010 to 0100 on one edge with no zero cycle. The net driven 0 by owner 1 and 1 by owner 2 never reads x.
5. Release and MAX_HOLD expiry in the same cycle -> preempt stays 0 and normal gap follows. req on a non-owner rising during GAP -> granted on the edge after the last gap cycle.
6. rst_n asserted low mid-OWN between clock edges -> oe=0 and bus_busy=0 immediately. After release with req=4'b1000, owner=3 one cycle after the first clock edge.
